// File: rtl/nixie_pkg.sv
// Shared definitions for the nixie clock time editor: state encoding, digit
// indices and per-digit BCD limits.
package nixie_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_EDIT = 1'b1
    } state_t;

    localparam logic [2:0] SEC_ONES = 3'd0;
    localparam logic [2:0] SEC_TENS = 3'd1;
    localparam logic [2:0] MIN_ONES = 3'd2;
    localparam logic [2:0] MIN_TENS = 3'd3;
    localparam logic [2:0] HR_ONES  = 3'd4;
    localparam logic [2:0] HR_TENS  = 3'd5;

    localparam logic [2:0] CURSOR_MAX = HR_TENS;

    localparam logic [3:0] LIM_SEC_ONES    = 4'd9;
    localparam logic [3:0] LIM_SEC_TENS    = 4'd5;
    localparam logic [3:0] LIM_MIN_ONES    = 4'd9;
    localparam logic [3:0] LIM_MIN_TENS    = 4'd5;
    localparam logic [3:0] LIM_HR_ONES     = 4'd9;
    localparam logic [3:0] LIM_HR_ONES_20S = 4'd3;
    localparam logic [3:0] LIM_HR_TENS     = 4'd2;

    // Hour ones limit depends on the current hour tens digit (20-23).
    function automatic logic [3:0] digit_limit(input logic [2:0] idx,
                                               input logic [3:0] hr_tens);
        case (idx)
            SEC_ONES: digit_limit = LIM_SEC_ONES;
            SEC_TENS: digit_limit = LIM_SEC_TENS;
            MIN_ONES: digit_limit = LIM_MIN_ONES;
            MIN_TENS: digit_limit = LIM_MIN_TENS;
            HR_ONES:  digit_limit = (hr_tens == LIM_HR_TENS) ? LIM_HR_ONES_20S : LIM_HR_ONES;
            HR_TENS:  digit_limit = LIM_HR_TENS;
            default:  digit_limit = LIM_SEC_ONES;
        endcase
    endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// 24-bit packed BCD HHMMSS time register with one-second increment and
// parallel load; 23:59:59 wraps to 00:00:00. Load wins over increment.
module bcd_time_counter
    import nixie_pkg::*;
#(
    parameter logic [23:0] RESET_TIME = 24'h000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_inc,
    input  logic        i_load,
    input  logic [23:0] i_load_value,
    output logic [23:0] o_time
);

    logic [23:0] r_time;
    logic [23:0] w_next;

    always_comb begin
        w_next = r_time;
        if (r_time[3:0] != LIM_SEC_ONES) begin
            w_next[3:0] = r_time[3:0] + 4'd1;
        end else begin
            w_next[3:0] = '0;
            if (r_time[7:4] != LIM_SEC_TENS) begin
                w_next[7:4] = r_time[7:4] + 4'd1;
            end else begin
                w_next[7:4] = '0;
                if (r_time[11:8] != LIM_MIN_ONES) begin
                    w_next[11:8] = r_time[11:8] + 4'd1;
                end else begin
                    w_next[11:8] = '0;
                    if (r_time[15:12] != LIM_MIN_TENS) begin
                        w_next[15:12] = r_time[15:12] + 4'd1;
                    end else begin
                        w_next[15:12] = '0;
                        if (r_time[23:16] == {LIM_HR_TENS, LIM_HR_ONES_20S}) begin
                            w_next[23:16] = '0;
                        end else if (r_time[19:16] == LIM_HR_ONES) begin
                            w_next[19:16] = '0;
                            w_next[23:20] = r_time[23:20] + 4'd1;
                        end else begin
                            w_next[19:16] = r_time[19:16] + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_time <= RESET_TIME;
        end else if (i_load) begin
            r_time <= i_load_value;
        end else if (i_inc) begin
            r_time <= w_next;
        end
    end

    assign o_time = r_time;

endmodule

// File: rtl/time_edit_controller.sv
// Nixie clock RUN/EDIT controller: runs the BCD time, edits one digit at a time
// under a cursor. Define NIXIE_CURSOR_BLINK_EN to blink the cursor LED at 1 Hz.
module time_edit_controller
    import nixie_pkg::*;
#(
    parameter logic [23:0] RESET_TIME = 24'h000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick_1hz,
    input  logic        set,
    input  logic        left,
    input  logic        right,
    input  logic        up,
    input  logic        down,
    output logic [23:0] time_bcd,
    output logic [2:0]  cursor_pos,
    output logic [7:0]  led_values,
    output logic        edit_mode
);

    state_t      r_state;
    logic [2:0]  r_cursor;
    logic [7:0]  r_led;
    logic        r_edit_mode;

    logic [23:0] w_time;
    logic [23:0] w_edit_time;
    logic [23:0] w_load_value;
    logic        w_load;
    logic        w_inc;
    logic [3:0]  w_sel_dig;
    logic [3:0]  w_new_dig;
    logic [3:0]  w_lim;
    logic [2:0]  w_cursor_next;
    logic [7:0]  w_led_onehot;
    logic [7:0]  w_led_enter;
    logic [7:0]  w_led_edit;

    // Digit edit uses the pre-move cursor; no carry between digits.
    always_comb begin
        w_sel_dig = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (r_cursor == 3'(i)) w_sel_dig = w_time[4*i +: 4];
        end
        w_lim     = digit_limit(r_cursor, w_time[23:20]);
        w_new_dig = w_sel_dig;
        if (up && !down) begin
            w_new_dig = (w_sel_dig >= w_lim) ? 4'd0 : w_sel_dig + 4'd1;
        end else if (down && !up) begin
            w_new_dig = (w_sel_dig == 4'd0) ? w_lim : w_sel_dig - 4'd1;
        end
        w_edit_time = w_time;
        for (int unsigned i = 0; i < 6; i++) begin
            if (r_cursor == 3'(i)) w_edit_time[4*i +: 4] = w_new_dig;
        end
        if (w_edit_time[23:20] == LIM_HR_TENS && w_edit_time[19:16] > LIM_HR_ONES_20S) begin
            w_edit_time[19:16] = LIM_HR_ONES_20S;
        end
    end

    always_comb begin
        w_cursor_next = r_cursor;
        if (left && !right) begin
            w_cursor_next = (r_cursor == CURSOR_MAX) ? 3'd0 : r_cursor + 3'd1;
        end else if (right && !left) begin
            w_cursor_next = (r_cursor == 3'd0) ? CURSOR_MAX : r_cursor - 3'd1;
        end
    end

    assign w_led_onehot = 8'd1 << w_cursor_next;
    assign w_led_enter  = 8'd1 << r_cursor;

    // Leaving EDIT reloads the time with seconds cleared.
    assign w_load       = (r_state == ST_EDIT);
    assign w_load_value = set ? {w_time[23:8], 8'h00} : w_edit_time;
    assign w_inc        = !set && (r_state == ST_RUN) && tick_1hz;

`ifdef NIXIE_CURSOR_BLINK_EN
    logic r_lit;
    logic w_lit_next;

    assign w_lit_next = (left ^ right) ? 1'b1 : (tick_1hz ? ~r_lit : r_lit);
    assign w_led_edit = w_lit_next ? w_led_onehot : 8'h00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lit <= 1'b1;
        end else if (set) begin
            r_lit <= 1'b1;
        end else if (r_state == ST_EDIT) begin
            r_lit <= w_lit_next;
        end
    end
`else
    assign w_led_edit = w_led_onehot;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_RUN;
            r_cursor    <= '0;
            r_led       <= '0;
            r_edit_mode <= 1'b0;
        end else if (set) begin
            if (r_state == ST_RUN) begin
                r_state     <= ST_EDIT;
                r_edit_mode <= 1'b1;
                r_led       <= w_led_enter;
            end else begin
                r_state     <= ST_RUN;
                r_edit_mode <= 1'b0;
                r_led       <= '0;
            end
        end else if (r_state == ST_EDIT) begin
            r_cursor <= w_cursor_next;
            r_led    <= w_led_edit;
        end
    end

    bcd_time_counter #(
        .RESET_TIME(RESET_TIME)
    ) u_counter (
        .i_clk        (clk),
        .i_rst_n      (reset_n),
        .i_inc        (w_inc),
        .i_load       (w_load),
        .i_load_value (w_load_value),
        .o_time       (w_time)
    );

    assign time_bcd   = w_time;
    assign cursor_pos = r_cursor;
    assign led_values = r_led;
    assign edit_mode  = r_edit_mode;

endmodule

// File: tb/tb_time_edit_controller.sv
// Bench for time_edit_controller: directed scenarios plus random pulses checked
// against an hours/minutes/seconds reference model (default build, steady LED).
module tb_time_edit_controller;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        tick_1hz = 1'b0;
    logic        set      = 1'b0;
    logic        left     = 1'b0;
    logic        right    = 1'b0;
    logic        up       = 1'b0;
    logic        down     = 1'b0;
    logic [23:0] time_bcd;
    logic [2:0]  cursor_pos;
    logic [7:0]  led_values;
    logic        edit_mode;

    int n_checks = 0;
    int n_errors = 0;

    int m_hh = 0;
    int m_mm = 0;
    int m_ss = 0;
    int m_cur = 0;
    bit m_edit = 1'b0;

    time_edit_controller #(
        .RESET_TIME(24'h000000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick_1hz   (tick_1hz),
        .set        (set),
        .left       (left),
        .right      (right),
        .up         (up),
        .down       (down),
        .time_bcd   (time_bcd),
        .cursor_pos (cursor_pos),
        .led_values (led_values),
        .edit_mode  (edit_mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] m_bcd();
        return {4'(m_hh / 10), 4'(m_hh % 10), 4'(m_mm / 10), 4'(m_mm % 10),
                4'(m_ss / 10), 4'(m_ss % 10)};
    endfunction

    function automatic logic [7:0] m_led();
        return m_edit ? 8'(1 << m_cur) : 8'h00;
    endfunction

    task automatic model_reset();
        m_hh = 0; m_mm = 0; m_ss = 0; m_cur = 0; m_edit = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit t, input bit l, input bit r,
                              input bit u, input bit d);
        int dg[6];
        int lim;
        int tot;
        if (s) begin
            if (m_edit) m_ss = 0;
            m_edit = !m_edit;
        end else if (!m_edit) begin
            if (t) begin
                tot  = (m_hh * 3600 + m_mm * 60 + m_ss + 1) % 86400;
                m_hh = tot / 3600;
                m_mm = (tot / 60) % 60;
                m_ss = tot % 60;
            end
        end else begin
            dg[0] = m_ss % 10; dg[1] = m_ss / 10;
            dg[2] = m_mm % 10; dg[3] = m_mm / 10;
            dg[4] = m_hh % 10; dg[5] = m_hh / 10;
            case (m_cur)
                0, 2:    lim = 9;
                1, 3:    lim = 5;
                4:       lim = (dg[5] == 2) ? 3 : 9;
                default: lim = 2;
            endcase
            if (u && !d)      dg[m_cur] = (dg[m_cur] >= lim) ? 0 : dg[m_cur] + 1;
            else if (d && !u) dg[m_cur] = (dg[m_cur] == 0) ? lim : dg[m_cur] - 1;
            if (dg[5] == 2 && dg[4] > 3) dg[4] = 3;
            m_ss = dg[1] * 10 + dg[0];
            m_mm = dg[3] * 10 + dg[2];
            m_hh = dg[5] * 10 + dg[4];
            if (l && !r)      m_cur = (m_cur + 1) % 6;
            else if (r && !l) m_cur = (m_cur + 5) % 6;
        end
    endtask

    task automatic step(input bit s, input bit t, input bit l, input bit r,
                        input bit u, input bit d);
        @(negedge clk);
        set = s; tick_1hz = t; left = l; right = r; up = u; down = d;
        @(posedge clk);
        model_step(s, t, l, r, u, d);
        #1;
        set = 1'b0; tick_1hz = 1'b0; left = 1'b0; right = 1'b0; up = 1'b0; down = 1'b0;
        check("time",   32'(time_bcd),   32'(m_bcd()));
        check("cursor", 32'(cursor_pos), 32'(m_cur));
        check("led",    32'(led_values), 32'(m_led()));
        check("edit",   32'(edit_mode),  32'(m_edit));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_time"},   32'(time_bcd),   32'h000000);
        check({tag, "_cursor"}, 32'(cursor_pos), 32'd0);
        check({tag, "_led"},    32'(led_values), 32'h00);
        check({tag, "_edit"},   32'(edit_mode),  32'd0);
    endtask

    initial begin
        #12;
        check_reset_values("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // 61 seconds from reset
        for (int i = 0; i < 61; i++) step(0, 1, 0, 0, 0, 0);
        check("sec61_time", 32'(time_bcd),   32'h000101);
        check("sec61_edit", 32'(edit_mode),  32'd0);
        check("sec61_led",  32'(led_values), 32'h00);

        // hour tens wraps 0..2 at cursor 5
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        check("hrt_cursor", 32'(cursor_pos),     32'd5);
        check("hrt_led",    32'(led_values),     32'h20);
        check("hrt_two",    32'(time_bcd[23:20]), 32'd2);
        step(0, 0, 0, 0, 1, 0);
        check("hrt_wrap",   32'(time_bcd[23:20]), 32'd0);

        // build 23:59 and wrap through midnight
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        check("exit_clear", 32'(time_bcd), 32'h235900);
        for (int i = 0; i < 59; i++) step(0, 1, 0, 0, 0, 0);
        check("pre_wrap",   32'(time_bcd), 32'h235959);
        step(0, 1, 0, 0, 0, 0);
        check("midnight",   32'(time_bcd), 32'h000000);

        // 19:30:45 -> hour tens up clamps hour ones to 3
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 45; i++) step(0, 1, 0, 0, 0, 0);
        check("t193045", 32'(time_bcd), 32'h193045);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check("clamp",   32'(time_bcd), 32'h233045);
        step(1, 0, 0, 0, 0, 0);
        check("exit_time", 32'(time_bcd),  32'h233000);
        check("exit_edit", 32'(edit_mode), 32'd0);

        // simultaneous pulses, set priority, RUN ignores edit keys
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        check("updown",    32'(time_bcd),   32'h233000);
        step(0, 0, 1, 1, 0, 0);
        check("leftright", 32'(cursor_pos), 32'd5);
        step(0, 1, 0, 0, 0, 0);
        check("edit_pause", 32'(time_bcd),  32'h233000);
        step(1, 1, 1, 0, 1, 0);
        check("set_tick_time", 32'(time_bcd),   32'h233000);
        check("set_tick_cur",  32'(cursor_pos), 32'd5);
        step(0, 0, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0, 1);
        check("run_ignore_cur",  32'(cursor_pos), 32'd5);
        check("run_ignore_time", 32'(time_bcd),   32'h233000);

        // random pulses
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(19, 0) == 0, $urandom_range(3, 0) == 0,
                 $urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0,
                 $urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0);
        end

        // asynchronous reset in the middle of an edit
        if (!m_edit) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("midreset");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 1, 0, 0, 0, 0);
        check("after_reset", 32'(time_bcd), 32'h000001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
